// File: rtl/uart_fifo_pkg.sv
// Shared constants and entry layout for the UART16550 TX/RX FIFOs.
// Error bits sit above the data bits in each stored entry.
package uart_fifo_pkg;

  localparam int UART_DWIDTH     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_EWIDTH     = 3;

  // Bit positions inside the RX error field {break, framing, parity}
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_BREAK   = 2;

  typedef struct packed {
    logic [UART_EWIDTH-1:0] err;
    logic [UART_DWIDTH-1:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DWIDTH = UART_DWIDTH,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int EWIDTH = UART_EWIDTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int W     = EWIDTH + DWIDTH
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_fifo_pro.sv
// Circular-buffer FIFO with occupancy counter, per-entry error bits and an
// error-in-FIFO flag, for the UART16550 TX/RX paths.
module uart_fifo_pro
  import uart_fifo_pkg::*;
#(
  parameter int DWIDTH = UART_DWIDTH,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int EWIDTH = UART_EWIDTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [DWIDTH-1:0] din,
  input  logic [EWIDTH-1:0] ein,
  input  logic [CW-1:0]     threshold,
  output logic [DWIDTH-1:0] dout,
  output logic [EWIDTH-1:0] eout,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              thre_trigger,
  output logic              overrun,
  output logic              underrun,
  output logic              err_in_fifo
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo_pro: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [EWIDTH-1:0] err;
    logic [DWIDTH-1:0] data;
  } entry_t;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_err_cnt;
  logic          r_overrun;
  logic          r_underrun;

  logic   w_empty;
  logic   w_full;
  logic   w_clear;
  logic   w_pop;
  logic   w_push;
  logic   w_err_in;
  logic   w_err_out;
  entry_t w_wentry;
  entry_t w_rentry;
  entry_t w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_clear = flush | ~en;

  // A push into a full FIFO is only legal when the head leaves on the same edge
  assign w_pop  = pop_in & ~w_empty;
  assign w_push = push_in & (~w_full | w_pop);

  assign w_wentry.err  = ein;
  assign w_wentry.data = din;

  uart_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .EWIDTH (EWIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~w_clear & ~rst),
    .i_waddr (r_wptr),
    .i_wdata (w_wentry),
    .i_raddr (r_rptr),
    .o_rdata (w_rentry)
  );

  assign w_head    = w_empty ? '0 : w_rentry;
  assign w_err_in  = w_push & (|ein);
  assign w_err_out = w_pop & (|w_head.err);

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err_cnt  <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case ({w_err_in, w_err_out})
        2'b10:   r_err_cnt <= r_err_cnt + CW'(1);
        2'b01:   r_err_cnt <= r_err_cnt - CW'(1);
        default: r_err_cnt <= r_err_cnt;
      endcase

      r_overrun  <= push_in & w_full & ~w_pop;
      r_underrun <= pop_in & w_empty;
    end
  end

  assign dout         = w_head.data;
  assign eout         = w_head.err;
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = r_count;
  // count never exceeds DEPTH, so thresholds above DEPTH never trigger
  assign thre_trigger = (threshold != '0) & (r_count >= threshold);
  assign overrun      = r_overrun;
  assign underrun     = r_underrun;
  assign err_in_fifo  = (r_err_cnt != '0);

endmodule

// File: tb/tb_uart_fifo_pro.sv
// Directed self-checking bench for uart_fifo_pro at DEPTH=16.
module tb_uart_fifo_pro;
  import uart_fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int EW = 3;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst, en, flush, push_in, pop_in;
  logic [DW-1:0] din;
  logic [EW-1:0] ein;
  logic [CW-1:0] threshold;
  logic [DW-1:0] dout;
  logic [EW-1:0] eout;
  logic          empty, full, thre_trigger, overrun, underrun, err_in_fifo;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  uart_fifo_pro #(.DWIDTH(DW), .DEPTH(DP), .EWIDTH(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .flush        (flush),
    .push_in      (push_in),
    .pop_in       (pop_in),
    .din          (din),
    .ein          (ein),
    .threshold    (threshold),
    .dout         (dout),
    .eout         (eout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .thre_trigger (thre_trigger),
    .overrun      (overrun),
    .underrun     (underrun),
    .err_in_fifo  (err_in_fifo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d, input logic [EW-1:0] e);
    push_in = 1'b1; din = d; ein = e;
    step();
    push_in = 1'b0; ein = '0;
  endtask

  task automatic pop_one();
    pop_in = 1'b1;
    step();
    pop_in = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".empty"},    32'(empty),        32'd1);
    check({tag, ".full"},     32'(full),         32'd0);
    check({tag, ".count"},    32'(count),        32'd0);
    check({tag, ".thre"},     32'(thre_trigger), 32'd0);
    check({tag, ".overrun"},  32'(overrun),      32'd0);
    check({tag, ".underrun"}, 32'(underrun),     32'd0);
    check({tag, ".err"},      32'(err_in_fifo),  32'd0);
    check({tag, ".dout"},     32'(dout),         32'd0);
    check({tag, ".eout"},     32'(eout),         32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    din = '0; ein = '0; threshold = '0;
    step(); step();
    rst = 1'b0;
    check_reset_state("reset");

    // 1: fill, overrun, drain in order
    for (int i = 1; i <= 16; i++) push_one(DW'(i), '0);
    check("t1.count_full", 32'(count), 32'd16);
    check("t1.full",       32'(full),  32'd1);
    push_one(8'hAA, '0);
    check("t1.overrun_pulse", 32'(overrun), 32'd1);
    check("t1.count_kept",    32'(count),   32'd16);
    step();
    check("t1.overrun_clear", 32'(overrun), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("t1.pop%0d", i), 32'(dout), 32'(i));
      pop_one();
    end
    check("t1.empty", 32'(empty), 32'd1);
    check("t1.dout_empty", 32'(dout), 32'd0);

    // 2: simultaneous push and pop while full
    for (int i = 1; i <= 16; i++) push_one(DW'(i), '0);
    check("t2.head", 32'(dout), 32'h01);
    push_in = 1'b1; pop_in = 1'b1; din = 8'h55;
    step();
    push_in = 1'b0; pop_in = 1'b0;
    check("t2.count",   32'(count),   32'd16);
    check("t2.overrun", 32'(overrun), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("t2.pop%0d", i), 32'(dout), 32'(i));
      pop_one();
    end
    check("t2.last", 32'(dout), 32'h55);
    pop_one();
    check("t2.empty", 32'(empty), 32'd1);

    // 3: push and pop while empty
    push_in = 1'b1; pop_in = 1'b1; din = 8'h3C;
    step();
    push_in = 1'b0; pop_in = 1'b0;
    check("t3.underrun", 32'(underrun), 32'd1);
    check("t3.count",    32'(count),    32'd1);
    check("t3.dout",     32'(dout),     32'h3C);
    step();
    check("t3.underrun_clear", 32'(underrun), 32'd0);
    pop_one();
    check("t3.empty", 32'(empty), 32'd1);

    // 4: threshold trigger
    threshold = CW'(4);
    for (int i = 0; i < 3; i++) push_one(DW'(8'h40 + i), '0);
    check("t4.below", 32'(thre_trigger), 32'd0);
    push_one(8'h43, '0);
    check("t4.at", 32'(thre_trigger), 32'd1);
    pop_one();
    check("t4.after_pop", 32'(thre_trigger), 32'd0);
    push_one(8'h44, '0);
    threshold = '0;
    #1;
    check("t4.thr_zero", 32'(thre_trigger), 32'd0);
    threshold = CW'(17);
    for (int i = 0; i < 12; i++) push_one(DW'(i), '0);
    check("t4.full_for_thr17", 32'(count), 32'd16);
    check("t4.thr_above_depth", 32'(thre_trigger), 32'd0);
    threshold = CW'(16);
    #1;
    check("t4.thr_depth", 32'(thre_trigger), 32'd1);
    threshold = '0;
    do_flush();
    check("t4.flushed", 32'(count), 32'd0);

    // 5: error-in-FIFO tracking
    push_one(8'h11, '0);
    push_one(8'h22, EW'(1 << ERR_FRAMING));
    push_one(8'h33, '0);
    check("t5.err_set",   32'(err_in_fifo), 32'd1);
    check("t5.eout_head", 32'(eout),        32'd0);
    pop_one();
    check("t5.err_still", 32'(err_in_fifo), 32'd1);
    check("t5.eout_err",  32'(eout),        32'b010);
    check("t5.dout_22",   32'(dout),        32'h22);
    pop_one();
    check("t5.err_clear", 32'(err_in_fifo), 32'd0);
    check("t5.dout_33",   32'(dout),        32'h33);
    do_flush();

    // 6: flush with push, enable low, reset mid-stream
    push_one(8'h01, EW'(1 << ERR_BREAK));
    for (int i = 2; i <= 5; i++) push_one(DW'(i), '0);
    check("t6.count5", 32'(count),       32'd5);
    check("t6.err5",   32'(err_in_fifo), 32'd1);
    flush = 1'b1; push_in = 1'b1; din = 8'h77;
    step();
    flush = 1'b0; push_in = 1'b0;
    check("t6.flush_count",   32'(count),       32'd0);
    check("t6.flush_empty",   32'(empty),       32'd1);
    check("t6.flush_err",     32'(err_in_fifo), 32'd0);
    check("t6.flush_overrun", 32'(overrun),     32'd0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_one(8'h90, '0);
    check("t6.en_low_count", 32'(count), 32'd0);
    pop_one();
    check("t6.en_low_underrun", 32'(underrun), 32'd0);
    en = 1'b1;
    push_one(8'hA1, EW'(1 << ERR_PARITY));
    push_one(8'hA2, '0);
    check("t6.pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("t6.rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_pro.md
Name: uart_fifo_pro

Overview:
Parametrised successor FIFO for the UART16550 TX/RX paths.
- Circular buffer with an occupancy counter. Replaces the shift-register FIFO.
- Generalised in data width and depth.
- Adds per-entry error bits (parity, framing, break) and a 16550 LSR[7]-style error-in-FIFO flag.
- Adds a synchronous flush, a count output, and defined push/pop behaviour when full or empty.
- Sits between the UART register file (THR/RBR, FCR, LSR) and the TX/RX shift engines.

Parameters:
DWIDTH, 8, data bits per entry
DEPTH, 16, entries; must be a power of two and at least 2; elaboration-time assertion otherwise
EWIDTH, 3, error bits stored with each entry (RX: {break, framing, parity}; TX instance ties to 0)
CW, $clog2(DEPTH)+1, derived width of count and threshold; not user-overridable

Ports:
clk  in  1  single clock domain, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  FIFO enable (FCR[0]); 0 = FIFO held empty
flush  in  1  single-cycle clear request (FCR[1]/FCR[2])
push_in  in  1  write request
pop_in  in  1  read request
din  in  DWIDTH  write data
ein  in  EWIDTH  write error bits
threshold  in  CW  trigger level
dout  out  DWIDTH  head data, first-word fall-through
eout  out  EWIDTH  head error bits
empty  out  1  count==0
full  out  1  count==DEPTH
count  out  CW  current occupancy
thre_trigger  out  1  threshold reached
overrun  out  1  one-cycle pulse, write dropped
underrun  out  1  one-cycle pulse, read rejected
err_in_fifo  out  1  at least one stored entry has nonzero error bits

Behaviour:
- State: wptr and rptr, each log2(DEPTH) bits and wrapping DEPTH-1 -> 0; count (CW bits); err_cnt (CW bits).
- Reset, when rst=1 at a clk edge:
  - wptr, rptr, count and err_cnt go to 0.
  - Outputs: empty=1, full=0, count=0, thre_trigger=0, overrun=0, underrun=0, err_in_fifo=0, dout=0, eout=0.
  - Memory contents are not reset.
- Priority, highest first: rst > (flush or !en) > push/pop.
- Flush, or en=0:
  - Pointers, count and err_cnt go to 0 on that edge.
  - push_in/pop_in are ignored that cycle; no overrun or underrun pulse.
  - Applies equally mid-stream.
- Accepted pop: pop = pop_in & !empty.
- Accepted push: push = push_in & (!full | pop). A push while full is accepted only when a pop is accepted in the same cycle.
- On an edge with push accepted:
  - mem[wptr] <= {ein, din}.
  - wptr increments.
- On an edge with pop accepted: rptr increments.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop while empty: the pop is rejected (underrun pulses) and the push is accepted, so count becomes 1.
- err_cnt:
  - +1 when an accepted push has |ein.
  - -1 when an accepted pop removes a head entry with |eout.
  - Both in the same cycle: unchanged.
  - err_in_fifo = (err_cnt != 0).
- Head outputs:
  - dout and eout read mem[rptr] combinationally.
  - Both are forced to 0 when empty.
  - Written data is visible at the head one cycle after the push edge when the FIFO was empty.
- Status outputs:
  - empty, full and count derive combinationally from the registered count.
  - thre_trigger = (threshold != 0) & (count >= threshold). It is 0 if threshold > DEPTH.
- overrun: registered; 1 for exactly one cycle after an edge where push_in=1, full=1 and no pop was accepted. The data is dropped and state is unchanged.
- underrun: registered; 1 for exactly one cycle after an edge where pop_in=1 and empty=1.
- Back-to-back operation: one push and/or one pop per cycle, indefinitely. There are no bubbles.

Decomposition:
- Shared package uart_fifo_pkg:
  - Default constants UART_DWIDTH=8, UART_FIFO_DEPTH=16, UART_EWIDTH=3.
  - Parametrised entry struct typedef {err, data}.
  - Error-bit index constants ERR_PARITY=0, ERR_FRAMING=1, ERR_BREAK=2.
- One sub-module, uart_fifo_mem:
  - DEPTH x (EWIDTH+DWIDTH) register array.
  - Synchronous write port, asynchronous read port.
  - No reset.
- Pointer, count, flag and error logic stay in uart_fifo_pro.

Test Plan:
1. DEPTH=16; reset, then push 0x01..0x10 -> full=1 and count=16 after the 16th edge; a 17th push (0xAA) -> overrun pulses one cycle, count stays 16; pops return 0x01..0x10 in order, then empty=1.
2. Fill to 16, then assert push(0x55) and pop together -> pop returns 0x01, count stays 16, no overrun, and the last entry read out is 0x55.
3. Empty FIFO, pop_in with push_in(0x3C) -> underrun pulses, count=1, dout=0x3C next cycle.
4. threshold=4: push 3 -> thre_trigger=0; 4th push -> 1; one pop -> 0; threshold=0 -> always 0.
5. Push 0x11 (ein=0), 0x22 (ein=3'b010), 0x33 (ein=0) -> err_in_fifo=1; pop two -> err_in_fifo=0 after the second pop.
6. With 5 entries stored, assert flush together with push_in -> count=0, empty=1, err_in_fifo=0, no overrun; hold en=0 while pushing 3 -> count stays 0; rst mid-stream -> all outputs at reset values.
